// File: rtl/uart_arb_pkg.sv
// ============================================================================
// uart_arb_pkg : state encoding, source-tag base and round-robin pick helper
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_arb_pkg;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] TAG  = 2'd1;
   localparam logic [1:0] XFER = 2'd2;

   localparam logic [7:0] TAG_BASE = 8'hF0;

   // Largest supported requester count; the helper works on a fixed-width view.
   localparam int unsigned RR_MAX = 8;

   typedef struct packed {
      logic       found;
      logic [2:0] idx;
   } rr_pick_t;

   function automatic rr_pick_t rr_pick(
      input logic [RR_MAX-1:0] req,
      input logic [2:0]        ptr,
      input int unsigned       n
   );
      rr_pick_t r;
      int       j;
      r = '0;
      for (int k = 0; k < RR_MAX; k++) begin
         j = int'(ptr) + k;
         if (j >= int'(n)) begin
            j = j - int'(n);
         end
         if ((k < int'(n)) && !r.found && req[j[2:0]]) begin
            r.found = 1'b1;
            r.idx   = j[2:0];
         end
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/uart_arb_rr_pick.sv
// ============================================================================
// uart_arb_rr_pick : combinational rotate-priority encoder (first set bit at
// or above ptr_i, wrapping modulo NUM_REQ)
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_arb_rr_pick
   import uart_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   localparam int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   ptr_i,
   output logic               found_o,
   output logic [IDX_W-1:0]   idx_o
);

   logic [RR_MAX-1:0] req_ext;
   logic [2:0]        ptr_ext;
   rr_pick_t          pick;

   always_comb begin
      req_ext                = '0;
      req_ext[NUM_REQ-1:0]   = req_i;
      ptr_ext                = '0;
      ptr_ext[IDX_W-1:0]     = ptr_i;
      pick                   = rr_pick(req_ext, ptr_ext, NUM_REQ);
   end

   assign found_o = pick.found;
   assign idx_o   = IDX_W'(pick.idx);

endmodule

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// uart_tx_arbiter : packet-atomic round-robin sharing of one UART TX byte
// stream, with a per-grant byte watchdog.
// Optional macro UART_ARB_SRC_TAG_EN prefixes each packet with 8'hF0|grant_id.
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int DATA_W  = 8,
   parameter  int MAX_PKT = 256,
   localparam int IDX_W   = $clog2(NUM_REQ),
   localparam int CNT_W   = $clog2(MAX_PKT)
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      tx_valid,
   output logic [DATA_W-1:0]         tx_data,
   input  logic                      tx_ready,
   output logic [IDX_W-1:0]          grant_id,
   output logic                      busy,
   output logic                      trunc_pulse
);

   logic [1:0]        state_q,    state_d;
   logic [IDX_W-1:0]  rr_ptr_q,   rr_ptr_d;
   logic [IDX_W-1:0]  grant_id_q, grant_id_d;
   logic [CNT_W-1:0]  cnt_q,      cnt_d;
   logic              busy_q,     busy_d;
   logic              trunc_q,    trunc_d;

   logic              pick_found;
   logic [IDX_W-1:0]  pick_idx;
   logic              sel_valid;
   logic              sel_last;
   logic [DATA_W-1:0] sel_data;
   logic [IDX_W-1:0]  rr_next;
   logic              cnt_at_max;

   uart_arb_rr_pick #(
      .NUM_REQ (NUM_REQ)
   ) u_pick (
      .req_i   (req_valid),
      .ptr_i   (rr_ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_id_q == IDX_W'(i)) begin
            sel_valid = req_valid[i];
            sel_last  = req_last[i];
            sel_data  = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign rr_next    = (grant_id_q == IDX_W'(NUM_REQ-1)) ? '0 : grant_id_q + IDX_W'(1);
   assign cnt_at_max = (cnt_q == CNT_W'(MAX_PKT-1));

   // Owner's handshake passes straight through to the FIFO port.
   always_comb begin
      tx_valid  = 1'b0;
      tx_data   = '0;
      req_ready = '0;
      case (state_q)
`ifdef UART_ARB_SRC_TAG_EN
         TAG: begin
            tx_valid = 1'b1;
            tx_data  = DATA_W'(TAG_BASE) | DATA_W'(grant_id_q);
         end
`endif
         XFER: begin
            tx_valid = sel_valid;
            tx_data  = sel_data;
            for (int i = 0; i < NUM_REQ; i++) begin
               if (grant_id_q == IDX_W'(i)) begin
                  req_ready[i] = tx_ready;
               end
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_id_d = grant_id_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      trunc_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               grant_id_d = pick_idx;
               busy_d     = 1'b1;
               cnt_d      = '0;
`ifdef UART_ARB_SRC_TAG_EN
               state_d    = TAG;
`else
               state_d    = XFER;
`endif
            end
         end
`ifdef UART_ARB_SRC_TAG_EN
         TAG: begin
            if (tx_ready) begin
               state_d = XFER;
            end
         end
`endif
         XFER: begin
            if (sel_valid && tx_ready) begin
               if (sel_last || cnt_at_max) begin
                  // Release on the last byte wins over the watchdog.
                  state_d  = IDLE;
                  rr_ptr_d = rr_next;
                  busy_d   = 1'b0;
                  trunc_d  = !sel_last;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         grant_id_q <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         trunc_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_id_q <= grant_id_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         trunc_q    <= trunc_d;
      end
   end

   assign grant_id    = grant_id_q;
   assign busy        = busy_q;
   assign trunc_pulse = trunc_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// tb_uart_tx_arbiter : directed self-checking bench for uart_tx_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int MP = 4;
`ifdef UART_ARB_SRC_TAG_EN
   localparam int TAGC = 1;
`else
   localparam int TAGC = 0;
`endif

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic [NR-1:0]    req_valid = '0;
   logic [NR*DW-1:0] req_data = '0;
   logic [NR-1:0]    req_last = '0;
   logic [NR-1:0]    req_ready;
   logic             tx_valid;
   logic [DW-1:0]    tx_data;
   logic             tx_ready = 1'b1;
   logic [1:0]       grant_id;
   logic             busy;
   logic             trunc_pulse;

   uart_tx_arbiter #(
      .NUM_REQ (NR),
      .DATA_W  (DW),
      .MAX_PKT (MP)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_last    (req_last),
      .req_ready   (req_ready),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .grant_id    (grant_id),
      .busy        (busy),
      .trunc_pulse (trunc_pulse)
   );

   always #5 clock = ~clock;

   // Per-requester byte queues: {last, data}; popped[] advances on each accept.
   logic [8:0] mem [NR][64];
   int         tail   [NR] = '{default: 0};
   int         popped [NR] = '{default: 0};

   logic [9:0] obs [512];
   logic [9:0] exp_q [512];
   int         obs_n = 0;
   int         exp_n = 0;
   int         seg = 0;
   int         busy_cyc = 0;
   int         trunc_cyc = 0;
   bit         bp_mon = 1'b0;

   int         n_chk = 0;
   int         n_fail = 0;

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   initial begin : mon
      bit         stall_q;
      logic [7:0] stall_data;
      stall_q    = 1'b0;
      stall_data = '0;
      forever begin
         @(negedge clock);
         if (tx_valid && tx_ready && obs_n < 512) begin
            obs[obs_n] = {grant_id, tx_data};
            obs_n++;
         end
         for (int i = 0; i < NR; i++) begin
            if (req_valid[i] && req_ready[i]) popped[i]++;
         end
         if (busy)        busy_cyc++;
         if (trunc_pulse) trunc_cyc++;
         if (bp_mon) begin
            if (stall_q) begin
               chk_eq("stall_valid", {31'd0, tx_valid}, 32'd1);
               chk_eq("stall_data", {24'd0, tx_data}, {24'd0, stall_data});
            end
`ifndef UART_ARB_SRC_TAG_EN
            if (busy) begin
               chk_eq("ready_mirror", {31'd0, req_ready[grant_id]}, {31'd0, tx_ready});
               chk_eq("ready_others", {28'd0, req_ready & ~(4'b0001 << grant_id)}, 32'd0);
            end
`endif
            stall_q    = tx_valid && !tx_ready;
            stall_data = tx_data;
         end else begin
            stall_q = 1'b0;
         end
      end
   end

   initial begin : drv
      forever begin
         @(posedge clock);
         #1;
         for (int i = 0; i < NR; i++) begin
            if (popped[i] < tail[i]) begin
               req_valid[i]          = 1'b1;
               req_data[i*DW +: DW]  = mem[i][popped[i] % 64][7:0];
               req_last[i]           = mem[i][popped[i] % 64][8];
            end else begin
               req_valid[i]          = 1'b0;
               req_data[i*DW +: DW]  = '0;
               req_last[i]           = 1'b0;
            end
         end
      end
   end

   initial begin : guard
      #100000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   task automatic push(input int r, input logic [7:0] d, input logic l);
      mem[r][tail[r] % 64] = {l, d};
      tail[r]++;
   endtask

   task automatic expect_byte(input int r, input logic [7:0] d);
      exp_q[exp_n] = {2'(r), d};
      exp_n++;
   endtask

   task automatic expect_tag(input int r);
      if (TAGC == 1) expect_byte(r, 8'hF0 | 8'(r));
   endtask

   task automatic cmp_seg(input string tag);
      chk_eq({tag, "_count"}, obs_n, exp_n);
      for (int k = seg; k < exp_n; k++) begin
         chk_eq(tag, {22'd0, obs[k]}, {22'd0, exp_q[k]});
      end
      if (obs_n > exp_n) exp_n = obs_n;
      seg = exp_n;
   endtask

   task automatic wait_done(input int budget, input bit need_idle);
      bit done;
      done = 1'b0;
      for (int c = 0; c < budget && !done; c++) begin
         @(posedge clock);
         #2;
         done = 1'b1;
         for (int i = 0; i < NR; i++) begin
            if (popped[i] != tail[i]) done = 1'b0;
         end
         if (need_idle && busy) done = 1'b0;
      end
      chk_eq("wait_timeout", {31'd0, done}, 32'd1);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      for (int i = 0; i < NR; i++) tail[i] = popped[i];
      repeat (2) @(posedge clock);
      #2;
      reset_n = 1'b1;
      @(posedge clock);
      #2;
   endtask

   initial begin : main
      int         b0;
      int         t0;
      int         p0;
      bit         done;
      logic [3:0] pat;

      tx_ready = 1'b1;
      repeat (2) @(posedge clock);
      #2;
      chk_eq("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      chk_eq("rst_busy", {31'd0, busy}, 32'd0);
      chk_eq("rst_trunc", {31'd0, trunc_pulse}, 32'd0);
      chk_eq("rst_grant_id", {30'd0, grant_id}, 32'd0);
      chk_eq("rst_req_ready", {28'd0, req_ready}, 32'd0);
      reset_n = 1'b1;
      @(posedge clock);
      #2;

      // Single packet from requester 1
      b0 = busy_cyc;
      push(1, 8'h41, 1'b0);
      push(1, 8'h42, 1'b0);
      push(1, 8'h43, 1'b1);
      expect_tag(1);
      expect_byte(1, 8'h41);
      expect_byte(1, 8'h42);
      expect_byte(1, 8'h43);
      wait_done(40, 1'b1);
      cmp_seg("single");
      chk_eq("single_busy_cycles", busy_cyc - b0, 3 + TAGC);

      // rr_ptr now 2: requester 2 must beat requester 0
      push(0, 8'hC0, 1'b1);
      push(2, 8'hC2, 1'b1);
      expect_tag(2);
      expect_byte(2, 8'hC2);
      expect_tag(0);
      expect_byte(0, 8'hC0);
      wait_done(40, 1'b1);
      cmp_seg("rr_ptr");
      chk_eq("rr_grant_hold", {30'd0, grant_id}, 32'd0);

      // Contention from reset: two 2-byte packets per requester
      do_reset();
      for (int i = 0; i < NR; i++) begin
         for (int r = 0; r < 2; r++) begin
            push(i, 8'(i*16 + 2*r), 1'b0);
            push(i, 8'(i*16 + 2*r + 1), 1'b1);
         end
      end
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < NR; i++) begin
            expect_tag(i);
            expect_byte(i, 8'(i*16 + 2*r));
            expect_byte(i, 8'(i*16 + 2*r + 1));
         end
      end
      wait_done(120, 1'b1);
      cmp_seg("contend");

      // Backpressure: tx_ready pattern 1,0,0,1
      pat = 4'b1001;
      push(1, 8'hA0, 1'b0);
      push(1, 8'hA1, 1'b0);
      push(1, 8'hA2, 1'b0);
      push(1, 8'hA3, 1'b1);
      expect_tag(1);
      expect_byte(1, 8'hA0);
      expect_byte(1, 8'hA1);
      expect_byte(1, 8'hA2);
      expect_byte(1, 8'hA3);
      bp_mon = 1'b1;
      done   = 1'b0;
      for (int c = 0; c < 60 && !done; c++) begin
         @(posedge clock);
         #1;
         tx_ready = pat[c % 4];
         #1;
         done = (popped[1] == tail[1]) && !busy;
      end
      chk_eq("bp_timeout", {31'd0, done}, 32'd1);
      @(posedge clock);
      #2;
      bp_mon   = 1'b0;
      tx_ready = 1'b1;
      cmp_seg("backpress");

      // Watchdog: requester 2 never sets last, requester 3 pending
      do_reset();
      t0 = trunc_cyc;
      for (int k = 0; k < 6; k++) push(2, 8'(8'h20 + k), 1'b0);
      push(3, 8'h33, 1'b1);
      expect_tag(2);
      for (int k = 0; k < 4; k++) expect_byte(2, 8'(8'h20 + k));
      expect_tag(3);
      expect_byte(3, 8'h33);
      expect_tag(2);
      expect_byte(2, 8'h24);
      expect_byte(2, 8'h25);
      wait_done(80, 1'b0);
      repeat (3) @(posedge clock);
      #2;
      cmp_seg("watchdog");
      chk_eq("trunc_pulse_cycles", trunc_cyc - t0, 32'd1);
      chk_eq("wd_busy_hold", {31'd0, busy}, 32'd1);
      chk_eq("wd_grant_hold", {30'd0, grant_id}, 32'd2);

      // Reset mid-packet after two of five bytes
      do_reset();
      p0 = popped[1];
      for (int k = 0; k < 5; k++) push(1, 8'(8'h51 + k), (k == 4));
      expect_tag(1);
      expect_byte(1, 8'h51);
      expect_byte(1, 8'h52);
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(posedge clock);
         #2;
         done = (popped[1] - p0) >= 2;
      end
      chk_eq("mid_wait_timeout", {31'd0, done}, 32'd1);
      t0 = trunc_cyc;
      reset_n = 1'b0;
      #1;
      chk_eq("mid_rst_tx_valid", {31'd0, tx_valid}, 32'd0);
      chk_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk_eq("mid_rst_grant_id", {30'd0, grant_id}, 32'd0);
      chk_eq("mid_rst_req_ready", {28'd0, req_ready}, 32'd0);
      for (int i = 0; i < NR; i++) tail[i] = popped[i];
      repeat (2) @(posedge clock);
      #2;
      reset_n = 1'b1;
      @(posedge clock);
      #2;
      chk_eq("mid_rst_no_trunc", trunc_cyc - t0, 32'd0);
      cmp_seg("reset_mid");
      push(3, 8'hD3, 1'b1);
      push(0, 8'hD0, 1'b1);
      expect_tag(0);
      expect_byte(0, 8'hD0);
      expect_tag(3);
      expect_byte(3, 8'hD3);
      wait_done(40, 1'b1);
      cmp_seg("post_reset");

      // Single-byte packet from requester 3
      push(3, 8'h55, 1'b1);
      expect_tag(3);
      expect_byte(3, 8'h55);
      wait_done(40, 1'b1);
      cmp_seg("tag_pkt");

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
